// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream header inserter.
// The helpers work on a maximum-width lane vector; callers size-cast to their own width.
package axis_hdr_pkg;

    localparam int MAX_BYTES = 64;

    typedef logic [MAX_BYTES-1:0]   lanes_t;
    typedef logic [MAX_BYTES*8-1:0] wide_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY,
        TAIL
    } state_t;

    function automatic int popcount(input lanes_t v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    // MSB-aligned run of cnt ones inside an n-lane keep vector.
    function automatic lanes_t keep_from_count(input int cnt, input int n);
        lanes_t k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n && i >= n - cnt) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

    function automatic wide_beat_t shl_bytes(input wide_beat_t d, input int n);
        return d << (8 * n);
    endfunction

    function automatic wide_beat_t shr_bytes(input wide_beat_t d, input int n);
        return d >> (8 * n);
    endfunction

    function automatic wide_beat_t low_bytes_mask(input int n);
        wide_beat_t m;
        m = '1;
        return ~(m << (8 * n));
    endfunction

endpackage

// File: rtl/axis_hdr_insert_gen_byte_merge.sv
// Combinational merge of the H-byte residual with one payload beat: produces the
// realigned output beat, the residual carried to the next beat and the overflow flag.
module axis_hdr_byte_merge
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_WD-1:0]      i_res,
    input  logic [BYTE_CNT_WD-1:0]  i_res_cnt,
    input  logic [DATA_WD-1:0]      i_data,
    input  logic [DATA_BYTE_WD-1:0] i_keep,
    input  logic                    i_last,
    output logic [DATA_WD-1:0]      o_data,
    output logic [DATA_BYTE_WD-1:0] o_keep,
    output logic [DATA_WD-1:0]      o_res,
    output logic                    o_overflow,
    output logic [BYTE_CNT_WD-1:0]  o_tail_cnt
);

    int                 w_h;
    int                 w_k;
    int                 w_sum;
    logic [DATA_WD-1:0] w_data_m;

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        w_h        = int'(i_res_cnt);
        w_k        = i_last ? popcount(lanes_t'(i_keep)) : DATA_BYTE_WD;
        w_sum      = w_h + w_k;
        // Disabled lanes of the last beat are forced to zero before realignment.
        w_data_m   = i_data & ~DATA_WD'(low_bytes_mask(DATA_BYTE_WD - w_k));
        o_data     = DATA_WD'(shl_bytes(wide_beat_t'(i_res), DATA_BYTE_WD - w_h))
                   | DATA_WD'(shr_bytes(wide_beat_t'(w_data_m), w_h));
        o_res      = w_data_m & DATA_WD'(low_bytes_mask(w_h));
        o_overflow = i_last && (w_sum > DATA_BYTE_WD);
        o_keep     = '1;
        o_tail_cnt = '0;
        if (o_overflow) begin
            o_tail_cnt = BYTE_CNT_WD'(w_sum - DATA_BYTE_WD);
        end else if (i_last) begin
            o_keep = DATA_BYTE_WD'(keep_from_count(w_sum, DATA_BYTE_WD));
        end
    end

endmodule

// File: rtl/axis_hdr_insert_gen.sv
// AXI-Stream header inserter: prepends 0..N right-aligned header bytes to each packet,
// realigns the payload and emits an overflow tail beat through one registered output stage.
module axis_hdr_insert_gen
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WD-1:0]      r_res;
    logic [BYTE_CNT_WD-1:0]  r_res_cnt;
    logic [BYTE_CNT_WD-1:0]  r_tail_cnt;
    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;

    logic                    w_slot_free;
    logic                    w_pay_acc;
    logic                    w_hdr_acc;
    logic                    w_tail_fire;
    logic                    w_overflow;
    logic [DATA_WD-1:0]      w_merge_data;
    logic [DATA_WD-1:0]      w_res_nxt;
    logic [DATA_WD-1:0]      w_tail_data;
    logic [DATA_BYTE_WD-1:0] w_merge_keep;
    logic [DATA_BYTE_WD-1:0] w_tail_keep;
    logic [BYTE_CNT_WD-1:0]  w_tail_cnt;

    assign w_slot_free = !r_valid_out || ready_out;
    assign w_pay_acc   = valid_in && ready_in;
    assign w_hdr_acc   = valid_insert && ready_insert;
    assign w_tail_fire = (r_state == TAIL) && w_slot_free;

    // Overflow bytes sit at the top of the residual; shift them up to lane 0.
    assign w_tail_data = DATA_WD'(shl_bytes(wide_beat_t'(r_res), DATA_BYTE_WD - int'(r_res_cnt)));
    assign w_tail_keep = DATA_BYTE_WD'(keep_from_count(int'(r_tail_cnt), DATA_BYTE_WD));

    axis_hdr_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_merge (
        .i_res      (r_res),
        .i_res_cnt  (r_res_cnt),
        .i_data     (data_in),
        .i_keep     (keep_in),
        .i_last     (last_in),
        .o_data     (w_merge_data),
        .o_keep     (w_merge_keep),
        .o_res      (w_res_nxt),
        .o_overflow (w_overflow),
        .o_tail_cnt (w_tail_cnt)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_hdr_acc) w_state_nxt = HDR;
            HDR, BODY: begin
                if (w_pay_acc) begin
                    if (!last_in)        w_state_nxt = BODY;
                    else if (w_overflow) w_state_nxt = TAIL;
                    else                 w_state_nxt = IDLE;
                end
            end
            TAIL: if (w_slot_free) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_insert = 1'b0;
        ready_in     = 1'b0;
        if (!rst) begin
            ready_insert = (r_state == IDLE);
            ready_in     = ((r_state == HDR) || (r_state == BODY)) && w_slot_free;
        end
    end

    // NOTE: the residual and its counts are reset too, so a mid-packet reset leaves no stale bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
            r_res       <= '0;
            r_res_cnt   <= '0;
            r_tail_cnt  <= '0;
        end else begin
            if (w_pay_acc) begin
                r_valid_out <= 1'b1;
                r_data_out  <= w_merge_data;
                r_keep_out  <= w_merge_keep;
                r_last_out  <= last_in && !w_overflow;
                r_res       <= w_res_nxt;
                r_tail_cnt  <= w_tail_cnt;
            end else if (w_tail_fire) begin
                r_valid_out <= 1'b1;
                r_data_out  <= w_tail_data;
                r_keep_out  <= w_tail_keep;
                r_last_out  <= 1'b1;
            end else if (ready_out) begin
                r_valid_out <= 1'b0;
            end
            if (w_hdr_acc) begin
                r_res     <= data_insert;
                r_res_cnt <= BYTE_CNT_WD'(popcount(lanes_t'(keep_insert)));
            end
        end
    end

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign keep_out  = r_keep_out;
    assign last_out  = r_last_out;

endmodule

// File: tb/tb_axis_hdr_insert_gen.sv
// Directed bench for axis_hdr_insert_gen: a byte-stream model predicts every output beat,
// and literal expectations pin the model on the documented packets.
module tb_axis_hdr_insert_gen;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;
    logic        valid_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic        ready_insert;

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    logic [31:0] p_data[0:7];
    logic [3:0]  p_keep[0:7];
    int    p_n;
    int    acc_cyc0, out_cyc0, last_gap, gap_cnt;
    bit    in_pkt, prev_stall;
    beat_t prev_b;
    bit    rp_en = 1'b0;
    int    rp_base = 0;
    bit    rp[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    axis_hdr_insert_gen dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .valid_insert (valid_insert),
        .data_insert  (data_insert),
        .keep_insert  (keep_insert),
        .ready_insert (ready_insert)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ready_out = rp_en ? rp[(cyc - rp_base) % 6] : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Model: header bytes then payload bytes form one byte stream, cut into N-byte beats.
    task automatic model_pkt(input logic [31:0] hd, input logic [3:0] hk);
        logic [7:0] bq[$];
        int h;
        h = $countones(hk);
        for (int j = h - 1; j >= 0; j--) bq.push_back(hd[8*j +: 8]);
        for (int b = 0; b < p_n; b++) begin
            int kc;
            kc = (b == p_n - 1) ? $countones(p_keep[b]) : 4;
            for (int i = 0; i < kc; i++) bq.push_back(p_data[b][31-8*i -: 8]);
        end
        while (bq.size() > 0) begin
            beat_t bt;
            bt.d = '0;
            bt.k = '0;
            for (int i = 0; i < 4 && bq.size() > 0; i++) begin
                bt.d[31-8*i -: 8] = bq.pop_front();
                bt.k[3-i] = 1'b1;
            end
            bt.l = (bq.size() == 0);
            exp_q.push_back(bt);
        end
    endtask

    task automatic drive_beat(input int i);
        valid_in = 1'b1;
        data_in  = p_data[i];
        keep_in  = p_keep[i];
        last_in  = (i == p_n - 1);
    endtask

    task automatic send_pkt(input logic [31:0] hd, input logic [3:0] hk);
        int i;
        int budget;
        bit h_ok, a_h, a_p;
        i = 0;
        budget = 0;
        h_ok = 1'b0;
        model_pkt(hd, hk);
        valid_insert = 1'b1;
        data_insert  = hd;
        keep_insert  = hk;
        drive_beat(0);
        while ((i < p_n || !h_ok) && budget < 200) begin
            @(negedge clk);
            a_h = valid_insert && ready_insert;
            a_p = valid_in && ready_in;
            if (a_p && i == 0) acc_cyc0 = cyc;
            @(posedge clk);
            #1;
            if (a_h) begin
                h_ok = 1'b1;
                valid_insert = 1'b0;
            end
            if (a_p) begin
                i++;
                if (i < p_n) drive_beat(i);
                else valid_in = 1'b0;
            end
            budget++;
        end
        if (budget >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: accepted %0d beats want %0d", i, p_n);
            valid_in = 1'b0;
            valid_insert = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || valid_out) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d beats left want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_t1();
        p_n = 2;
        p_data[0] = 32'h11223344; p_keep[0] = 4'b1111;
        p_data[1] = 32'h55667788; p_keep[1] = 4'b1100;
    endtask

    task automatic check_obs(input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
        if (obs_q.size() > idx) begin
            check($sformatf("obs%0d", idx), {obs_q[idx].l, obs_q[idx].k, obs_q[idx].d}, {l, k, d});
        end else begin
            n_vec++;
            n_bad++;
            $display("FAIL obs%0d: got %0d beats want more than %0d", idx, obs_q.size(), idx);
        end
    endtask

    always @(negedge clk) begin
        beat_t e, g;
        if (rst) begin
            prev_stall = 1'b0;
            in_pkt = 1'b0;
            gap_cnt = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {valid_out, last_out, keep_out, data_out},
                      {1'b1, prev_b.l, prev_b.k, prev_b.d});
            end
            g.d = data_out;
            g.k = keep_out;
            g.l = last_out;
            if (valid_out && ready_out) begin
                obs_q.push_back(g);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %0h want no beat", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {last_out, keep_out, data_out}, {e.l, e.k, e.d});
                end
                if (!in_pkt) begin
                    out_cyc0 = cyc;
                    last_gap = gap_cnt;
                    in_pkt = 1'b1;
                end
                if (last_out) begin
                    in_pkt = 1'b0;
                    gap_cnt = 0;
                end
            end else if (!valid_out && !in_pkt) begin
                gap_cnt++;
            end
            prev_stall = valid_out && !ready_out;
            prev_b = g;
        end
    end

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_out_fields", {last_out, keep_out, data_out}, 0);
        check("rst_ready_in", ready_in, 0);
        check("rst_ready_insert", ready_insert, 0);
        rst = 1'b0;
        #1;
        check("idle_ready_insert", ready_insert, 1);

        // Two-byte header, payload ends exactly on a beat boundary.
        load_t1();
        obs_q.delete();
        send_pkt(32'h0000AABB, 4'b0011);
        drain();
        check_obs(0, 32'hAABB1122, 4'b1111, 1'b0);
        check_obs(1, 32'h33445566, 4'b1111, 1'b1);
        check("t1_latency", out_cyc0 - acc_cyc0, 1);

        // Three-byte header on a single short beat overflows into a tail beat.
        p_n = 1;
        p_data[0] = 32'h11223344; p_keep[0] = 4'b1110;
        obs_q.delete();
        send_pkt(32'h00CCDDEE, 4'b0111);
        check("t2_ready_in_tail", ready_in, 0);
        drain();
        check_obs(0, 32'hCCDDEE11, 4'b1111, 1'b0);
        check_obs(1, 32'h22330000, 4'b1100, 1'b1);

        // Bypass: empty header passes beats through unchanged.
        p_n = 3;
        p_data[0] = 32'h01020304; p_keep[0] = 4'b1111;
        p_data[1] = 32'h05060708; p_keep[1] = 4'b1111;
        p_data[2] = 32'h09000000; p_keep[2] = 4'b1000;
        obs_q.delete();
        send_pkt(32'h12345678, 4'b0000);
        drain();
        check_obs(0, 32'h01020304, 4'b1111, 1'b0);
        check_obs(1, 32'h05060708, 4'b1111, 1'b0);
        check_obs(2, 32'h09000000, 4'b1000, 1'b1);
        check("t3_latency", out_cyc0 - acc_cyc0, 1);

        // Downstream backpressure pattern; the compare process checks every stall.
        load_t1();
        obs_q.delete();
        @(negedge clk);
        rp_base = cyc + 1;
        rp_en = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(32'h0000AABB, 4'b0011);
        drain();
        @(negedge clk);
        rp_en = 1'b0;
        @(posedge clk);
        #1;
        check_obs(0, 32'hAABB1122, 4'b1111, 1'b0);
        check_obs(1, 32'h33445566, 4'b1111, 1'b1);

        // Reset pulse while a beat is held in BODY.
        valid_insert = 1'b1; data_insert = 32'h0000AABB; keep_insert = 4'b0011;
        valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'b1111; last_in = 1'b0;
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
        @(posedge clk);
        #1;
        check("t5_body_beat", {valid_out, keep_out, data_out}, {1'b1, 4'b1111, 32'hAABB1122});
        rst = 1'b1;
        valid_in = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_valid_out", valid_out, 0);
        check("t5_keep_out", keep_out, 0);
        check("t5_ready_insert", ready_insert, 1);
        check("t5_ready_in", ready_in, 0);
        load_t1();
        obs_q.delete();
        send_pkt(32'h0000AABB, 4'b0011);
        drain();
        check_obs(0, 32'hAABB1122, 4'b1111, 1'b0);
        check_obs(1, 32'h33445566, 4'b1111, 1'b1);

        // Back-to-back packets: exactly one bubble between them.
        load_t1();
        send_pkt(32'h0000AABB, 4'b0011);
        send_pkt(32'h0000AABB, 4'b0011);
        drain();
        check("t6_gap", last_gap, 1);

        // Full-width header pushes the whole payload beat into the tail.
        p_n = 1;
        p_data[0] = 32'h11223344; p_keep[0] = 4'b1111;
        obs_q.delete();
        send_pkt(32'hDEADBEEF, 4'b1111);
        drain();
        check_obs(0, 32'hDEADBEEF, 4'b1111, 1'b0);
        check_obs(1, 32'h11223344, 4'b1111, 1'b1);

        check("model_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_hdr_insert_gen.md
Name: axis_hdr_insert_gen

Overview:
Parametrised AXI-Stream header inserter, successor to the fixed 32-bit header-insert pipe. Prepends a per-packet header of 0..DATA_BYTE_WD bytes to an AXI-Stream packet. Realigns every payload byte, emits an extra tail beat when the shifted payload overflows, and passes packets unmodified in bypass mode (empty header). Sits between a packet source and the downstream AXI-Stream sink, with a registered output and full-throughput streaming.

Parameters:
DATA_WD, 32, stream data width in bits; must be a multiple of 8.
DATA_BYTE_WD, DATA_WD/8, bytes per beat (N); must be at least 2.
BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1, width of internal byte counts (0..N).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
valid_in  in  1  payload beat valid.
data_in  in  DATA_WD  payload data; byte 0 is at [DATA_WD-1 -: 8].
keep_in  in  DATA_BYTE_WD  byte enables, MSB-aligned contiguous; all ones except on the last beat.
last_in  in  1  last payload beat.
ready_in  out  1  payload beat accepted when valid_in && ready_in.
valid_out  out  1  output beat valid.
data_out  out  DATA_WD  output data; disabled bytes are zero.
keep_out  out  DATA_BYTE_WD  output byte enables, MSB-aligned contiguous.
last_out  out  1  last output beat.
ready_out  in  1  downstream ready.
valid_insert  in  1  header valid.
data_insert  in  DATA_WD  header bytes, right-aligned.
keep_insert  in  DATA_BYTE_WD  header enables, right-aligned contiguous; H = popcount; 0 means bypass.
ready_insert  out  1  header accepted when valid_insert && ready_insert.

Behaviour:
- Reset (rst high at a clock edge): valid_out=0, data_out=0, keep_out=0, last_out=0, state=IDLE. ready_in and ready_insert are 0 while rst is high. Reset mid-packet discards all held bytes. The partial packet is not completed.
- States:
  - IDLE: ready_insert=1. Header accept captures H and the header bytes as the residual, then goes to HDR.
  - HDR: waits for the first payload beat, then goes to BODY. On last_in, goes straight to the end-of-packet handling.
  - BODY: streams payload beats.
  - TAIL: emits the overflow beat, then returns to IDLE.
- Output stage is a single register. The slot is free when !valid_out || ready_out.
- ready_in = (state==HDR || state==BODY) && slot free. TAIL and IDLE never accept payload.
- Beat merge on payload accept:
  - out = {residual H bytes, first N-H bytes of data_in}.
  - New residual = last H bytes of data_in.
  - Latency is 1 cycle from accept to valid_out.
  - Throughput is 1 beat per clock while ready_out=1.
- Last beat, with K = popcount(keep_in) in 1..N:
  - If H+K <= N: single output beat, keep_out = H+K ones MSB-aligned, last_out=1, next state IDLE.
  - Else: full beat with last_out=0, then TAIL emits the remaining H+K-N bytes with last_out=1.
- Bypass (H=0): output equals input beat-for-beat, including keep and last. A tail beat never occurs.
- Stall: while valid_out && !ready_out, all output signals hold stable. No beat is lost or duplicated.
- Inter-packet gap: exactly one output bubble cycle between packets when the header and data are presented without delay.
- Protocol violations: non-contiguous keep, or a zero keep on the last beat, is treated as the popcount value. The block must not deadlock.

Decomposition:
- Package axis_hdr_pkg holds:
  - state enum (IDLE, HDR, BODY, TAIL);
  - popcount function;
  - keep_from_count function (MSB-aligned ones);
  - byte-lane shift helpers.
- Sub-module axis_hdr_byte_merge: combinational merge of residual (H bytes) with the incoming beat. Outputs the merged beat, the next residual and the overflow flag. The top level holds the FSM, residual register and output register.

Test Plan:
1. N=4, header 0x0000AABB keep 0011; payload 0x11223344/1111, then 0x55667788/1100 last -> out 0xAABB1122/1111 last0, then 0x33445566/1111 last1; no tail.
2. Header 0x00CCDDEE keep 0111; single payload 0x11223344 keep 1110 last -> out 0xCCDDEE11/1111 last0, then tail 0x22330000/1100 last1; ready_in low during TAIL.
3. Bypass: keep_insert 0000, 3-beat packet, last beat keep 1000 -> output identical to input, one-cycle latency.
4. Test 1 with ready_out pattern 1,0,1,0,0,1 -> same data sequence; data_out/keep_out/last_out stable during every stall.
5. Reset pulse (one cycle) while in BODY with valid_out=1 -> next cycle valid_out=0, keep_out=0; ready_insert=1 the cycle after rst falls; the next packet is correct.
6. Back-to-back packets as in test 1 with ready_out=1 and headers pre-presented -> exactly one valid_out=0 cycle between packets.
